// File: rtl/mem_read_scheduler_pkg.sv
// Shared types and constants for the packet-SRAM read scheduler.
// Holds the FSM state enum, the egress tag, descriptor field offsets,
// the region bounds of the three-region SRAM and the address-width derivation.
package mem_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int EXTRA_W        = 2;
  localparam int SRC_W          = 2;
  localparam int DESC_START_LSB = 0;

  // Marker bundle that travels alongside each read so it lines up with i_data.
  typedef struct packed {
    logic               valid;
    logic               sof;
    logic               eof;
    logic [EXTRA_W-1:0] extra;
    logic [SRC_W-1:0]   src;
  } tag_t;

  function automatic int calc_aw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int desc_w(input int aw);
    return 2 * aw + EXTRA_W;
  endfunction

  function automatic int desc_end_lsb(input int aw);
    return aw;
  endfunction

  function automatic int desc_extra_lsb(input int aw);
    return 2 * aw;
  endfunction

  function automatic int region_lo(input int src);
    case (src)
      1:       return 1535;
      2:       return 3071;
      default: return 0;
    endcase
  endfunction

  // The last region runs to the top of the SRAM, so its bound follows the depth.
  function automatic int region_hi(input int src, input int depth);
    case (src)
      0:       return 1534;
      1:       return 3070;
      default: return depth - 1;
    endcase
  endfunction

endpackage

// File: rtl/mem_read_scheduler_if.sv
// Bank-side and egress-side signals of the read scheduler.
// master: the scheduler; slave: the SRAM bank plus egress MAC seen as one peer.
interface mem_read_scheduler_if #(
  parameter int AW = 13
) ();
  logic          i_tx_ready;
  logic          o_en_read;
  logic [AW-1:0] o_adr_out;
  logic [31:0]   i_data;
  logic [31:0]   o_data;
  logic          o_valid;
  logic          o_sof;
  logic          o_eof;
  logic [1:0]    o_extra_byte;
  logic [1:0]    o_src;

  modport master (
    input  i_tx_ready, i_data,
    output o_en_read, o_adr_out, o_data, o_valid, o_sof, o_eof, o_extra_byte, o_src
  );

  modport slave (
    output i_tx_ready, i_data,
    input  o_en_read, o_adr_out, o_data, o_valid, o_sof, o_eof, o_extra_byte, o_src
  );
endinterface

// File: rtl/mem_read_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after last_i.
// Kept generic so the ingress side can reuse it.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] last_i,
  output logic [N-1:0]  grant_o
);

  logic [SW-1:0] idx;
  logic          found;

  // Walk outward from the last grant; the nearest requester wins.
  always_comb begin
    grant_o = '0;
    idx     = '0;
    found   = 1'b0;
    for (int off = 1; off <= N; off++) begin
      idx = SW'((int'(last_i) + off) % N);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_read_scheduler.sv
// Read-side scheduler for the shared three-region packet SRAM.
// Pops end-of-frame descriptors round-robin, walks the frame's addresses with
// in-region wrap, and forwards the returned words to egress with frame markers.
// Optional build macro MEM_RD_SCHED_STATS_EN adds saturating per-source frame
// counters on o_frame_cnt.
module mem_read_scheduler
  import mem_sched_pkg::*;
#(
  parameter int pDEPTH_RAM = 4608,
  parameter int pN_SRC     = 3,
  parameter int pRD_LAT    = 2
) (
  input  logic                                        i_clk,
  input  logic                                        i_reset,
  input  logic [pN_SRC-1:0]                           i_desc_valid,
  input  logic [pN_SRC*(2*$clog2(pDEPTH_RAM)+2)-1:0]  i_desc,
  output logic [pN_SRC-1:0]                           o_desc_ready,
`ifdef MEM_RD_SCHED_STATS_EN
  output logic [pN_SRC*16-1:0]                        o_frame_cnt,
`endif
  mem_read_scheduler_if.master                        bus
);

  localparam int AW        = calc_aw(pDEPTH_RAM);
  localparam int DW        = desc_w(AW);
  localparam int END_LSB   = desc_end_lsb(AW);
  localparam int EXTRA_LSB = desc_extra_lsb(AW);
  localparam int DCW       = (pRD_LAT > 1) ? $clog2(pRD_LAT) : 1;
  localparam int PRE_IDX   = (pRD_LAT >= 2) ? pRD_LAT - 2 : 0;

  state_e          state_q;
  logic [AW-1:0]   adr_q, end_q;
  logic [1:0]      extra_q, src_q, last_grant_q;
  logic            en_read_q;
  tag_t            tag_q;
  logic [DCW-1:0]  drain_q;

  logic [pN_SRC-1:0] grant;
  logic [1:0]        g_idx;
  logic [DW-1:0]     sel_desc;
  logic [AW-1:0]     sel_start, sel_end, lo_adr, hi_adr, nxt_adr;
  logic [1:0]        sel_extra;
  logic              pop;

  rr_arbiter #(.N(pN_SRC), .SW(2)) u_arb (
    .req_i   (i_desc_valid),
    .last_i  (last_grant_q),
    .grant_o (grant)
  );

  // One-hot grant to source index.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < pN_SRC; i++) begin
      if (grant[i]) g_idx = 2'(i);
    end
  end

  assign sel_desc  = i_desc[int'(g_idx)*DW +: DW];
  assign sel_start = sel_desc[DESC_START_LSB +: AW];
  assign sel_end   = sel_desc[END_LSB +: AW];
  assign sel_extra = sel_desc[EXTRA_LSB +: EXTRA_W];

  // Pop is suppressed during reset so a descriptor is never lost to a flushed frame.
  assign pop          = i_reset && (state_q == ST_IDLE) && bus.i_tx_ready && (|i_desc_valid);
  assign o_desc_ready = pop ? grant : '0;

  // Wrap test precedes the increment, so end is always reachable within the region.
  assign lo_adr  = AW'(region_lo(int'(src_q)));
  assign hi_adr  = AW'(region_hi(int'(src_q), pDEPTH_RAM));
  assign nxt_adr = (adr_q == hi_adr) ? lo_adr : adr_q + AW'(1);

  // Frame sequencer with registered bank-side outputs and issue tag.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q      <= ST_IDLE;
      adr_q        <= '0;
      end_q        <= '0;
      extra_q      <= '0;
      src_q        <= '0;
      last_grant_q <= 2'(pN_SRC - 1);
      en_read_q    <= 1'b0;
      tag_q        <= '0;
      drain_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          en_read_q <= 1'b0;
          tag_q     <= '0;
          if (pop) begin
            state_q      <= ST_READ;
            adr_q        <= sel_start;
            end_q        <= sel_end;
            extra_q      <= sel_extra;
            src_q        <= g_idx;
            last_grant_q <= g_idx;
            en_read_q    <= 1'b1;
            tag_q        <= '{valid: 1'b1, sof: 1'b1, eof: (sel_start == sel_end),
                              extra: sel_extra, src: g_idx};
          end
        end
        ST_READ: begin
          if (adr_q == end_q) begin
            state_q   <= ST_DRAIN;
            en_read_q <= 1'b0;
            tag_q     <= '0;
            drain_q   <= DCW'(pRD_LAT - 1);
          end else begin
            adr_q     <= nxt_adr;
            en_read_q <= 1'b1;
            tag_q     <= '{valid: 1'b1, sof: 1'b0, eof: (nxt_adr == end_q),
                           extra: extra_q, src: src_q};
          end
        end
        ST_DRAIN: begin
          en_read_q <= 1'b0;
          tag_q     <= '0;
          if (drain_q == '0) state_q <= ST_IDLE;
          else               drain_q <= drain_q - DCW'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  tag_t        pipe_q [pRD_LAT];
  tag_t        pre_out;
  logic [31:0] data_q;

  // Stage feeding the output register; its valid marks the cycle i_data is live.
  always_comb begin
    pre_out = (pRD_LAT == 1) ? tag_q : pipe_q[PRE_IDX];
  end

  // Marker delay line and egress data capture.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int i = 0; i < pRD_LAT; i++) pipe_q[i] <= '0;
      data_q <= '0;
    end else begin
      pipe_q[0] <= tag_q;
      for (int i = 1; i < pRD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      data_q <= pre_out.valid ? bus.i_data : '0;
    end
  end

  assign bus.o_en_read    = en_read_q;
  assign bus.o_adr_out    = adr_q;
  assign bus.o_data       = data_q;
  assign bus.o_valid      = pipe_q[pRD_LAT-1].valid;
  assign bus.o_sof        = pipe_q[pRD_LAT-1].sof;
  assign bus.o_eof        = pipe_q[pRD_LAT-1].eof;
  assign bus.o_extra_byte = pipe_q[pRD_LAT-1].extra;
  assign bus.o_src        = pipe_q[pRD_LAT-1].src;

`ifdef MEM_RD_SCHED_STATS_EN
  logic [15:0] cnt_q [pN_SRC];

  // Saturating per-source pop counters.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int i = 0; i < pN_SRC; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < pN_SRC; i++) begin
        if (o_desc_ready[i] && (cnt_q[i] != 16'hFFFF)) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  // Flatten counters onto the stats port.
  always_comb begin
    o_frame_cnt = '0;
    for (int i = 0; i < pN_SRC; i++) o_frame_cnt[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_mem_read_scheduler.sv
// Scoreboard bench for mem_read_scheduler: a stimulus process predicts pops
// and pushes expected reads/words; a monitor checks them as the DUT emits them.
module tb_mem_read_scheduler;
  localparam int AW  = 13;
  localparam int DW  = 2 * AW + 2;
  localparam int NS  = 3;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              i_reset;
  logic [NS-1:0]     i_desc_valid;
  logic [NS*DW-1:0]  i_desc;
  logic [NS-1:0]     o_desc_ready;
`ifdef MEM_RD_SCHED_STATS_EN
  logic [NS*16-1:0]  o_frame_cnt;
`endif

  mem_read_scheduler_if #(.AW(AW)) bus ();

  mem_read_scheduler #(.pDEPTH_RAM(4608), .pN_SRC(NS), .pRD_LAT(LAT)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_desc_valid (i_desc_valid),
    .i_desc       (i_desc),
    .o_desc_ready (o_desc_ready),
`ifdef MEM_RD_SCHED_STATS_EN
    .o_frame_cnt  (o_frame_cnt),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int s; int e; int x; } desc_t;
  typedef struct { int adr; int cyc; } rd_t;
  typedef struct { logic [31:0] d; bit sof; bit eof; int x; int s; int cyc; } wd_t;

  desc_t fifo [NS][$];
  rd_t   rd_q [$];
  wd_t   wd_q [$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int last_g = NS - 1;
  int next_free = 0;
  int pops [NS];
  bit popped;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lo_of(input int s);
    return (s == 0) ? 0 : (s == 1) ? 1535 : 3071;
  endfunction
  function automatic int hi_of(input int s);
    return (s == 0) ? 1534 : (s == 1) ? 3070 : 4607;
  endfunction
  function automatic int step_adr(input int s, input int a);
    return (a == hi_of(s)) ? lo_of(s) : a + 1;
  endfunction
  function automatic int advance(input int s, input int a, input int n);
    int r = a;
    for (int i = 0; i < n; i++) r = step_adr(s, r);
    return r;
  endfunction
  function automatic logic [31:0] mem_word(input int a);
    return 32'hA500_0000 ^ (32'(a) * 32'h0001_0101);
  endfunction

  // Bank model: registered read, so data appears LAT cycles after the read strobe at o_data.
  always @(posedge clk) bus.i_data <= bus.o_en_read ? mem_word(int'(bus.o_adr_out)) : 32'hBAD0_BAD0;

  task automatic push(input int s, input int st, input int en, input int x);
    desc_t d;
    d.s = st; d.e = en; d.x = x;
    fifo[s].push_back(d);
  endtask

  task automatic drive();
    for (int s = 0; s < NS; s++) begin
      i_desc_valid[s] = (fifo[s].size() > 0);
      if (fifo[s].size() > 0)
        i_desc[s*DW +: DW] = {2'(fifo[s][0].x), 13'(fifo[s][0].e), 13'(fifo[s][0].s)};
      else
        i_desc[s*DW +: DW] = '0;
    end
  endtask

  // Expand a granted descriptor into expected reads and words.
  task automatic model_pop(input int g, input int t);
    desc_t d;
    int a, k;
    d = fifo[g].pop_front();
    a = d.s;
    k = 0;
    forever begin
      rd_t r;
      wd_t w;
      r.adr = a; r.cyc = t + 1 + k;
      rd_q.push_back(r);
      w.d = mem_word(a); w.sof = (k == 0); w.eof = (a == d.e);
      w.x = d.x; w.s = g; w.cyc = t + 1 + LAT + k;
      wd_q.push_back(w);
      if (a == d.e || k > 4700) break;
      a = step_adr(g, a);
      k++;
    end
    next_free = t + (k + 1) + 1 + LAT;
    last_g = g;
    pops[g]++;
  endtask

  task automatic step(input bit rstv, input bit txr);
    logic [NS-1:0] exp;
    int g;
    bit any;
    @(posedge clk);
    #1;
    i_reset = rstv;
    bus.i_tx_ready = txr;
    drive();
    @(negedge clk);
    exp = '0; g = 0; any = 1'b0; popped = 1'b0;
    for (int s = 0; s < NS; s++) if (fifo[s].size() > 0) any = 1'b1;
    if (rstv && txr && any && cyc >= next_free) begin
      for (int k = NS; k >= 1; k--) if (fifo[(last_g + k) % NS].size() > 0) g = (last_g + k) % NS;
      exp[g] = 1'b1;
    end
    checks++;
    if (o_desc_ready !== exp) begin
      failures++;
      $display("FAIL desc_ready: cyc %0d got %b want %b", cyc, o_desc_ready, exp);
    end
    if (exp != '0) begin
      model_pop(g, cyc);
      popped = 1'b1;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    bit busy = 1'b1;
    while (busy && n < budget) begin
      step(1'b1, 1'b1);
      n++;
      busy = (rd_q.size() > 0) || (wd_q.size() > 0);
      for (int s = 0; s < NS; s++) if (fifo[s].size() > 0) busy = 1'b1;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending words after %0d cycles, want 0", wd_q.size(), n);
    end
  endtask

  rd_t r_m;
  wd_t w_m;

  // Monitor: compares every read strobe and every egress word with the scoreboard.
  always @(negedge clk) begin
    if (bus.o_en_read === 1'b1) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL rd_spurious: got adr %0d at cyc %0d, want no read", bus.o_adr_out, cyc);
      end else begin
        r_m = rd_q.pop_front();
        if (r_m.adr != int'(bus.o_adr_out) || r_m.cyc != cyc) begin
          failures++;
          $display("FAIL rd_adr: got %0d@%0d want %0d@%0d", bus.o_adr_out, cyc, r_m.adr, r_m.cyc);
        end
      end
    end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
      checks++;
      failures++;
      $display("FAIL rd_missing: got no read at cyc %0d, want adr %0d", cyc, rd_q[0].adr);
      void'(rd_q.pop_front());
    end
    if (bus.o_valid === 1'b1) begin
      checks++;
      if (wd_q.size() == 0) begin
        failures++;
        $display("FAIL wd_spurious: got word %h at cyc %0d, want none", bus.o_data, cyc);
      end else begin
        w_m = wd_q.pop_front();
        if (w_m.d !== bus.o_data || w_m.cyc != cyc || w_m.sof != bus.o_sof ||
            w_m.eof != bus.o_eof || w_m.s != int'(bus.o_src) ||
            (w_m.eof && w_m.x != int'(bus.o_extra_byte))) begin
          failures++;
          $display("FAIL wd: got d=%h sof=%b eof=%b x=%0d src=%0d @%0d want d=%h sof=%b eof=%b x=%0d src=%0d @%0d",
                   bus.o_data, bus.o_sof, bus.o_eof, bus.o_extra_byte, bus.o_src, cyc,
                   w_m.d, w_m.sof, w_m.eof, w_m.x, w_m.s, w_m.cyc);
        end
      end
    end else if (wd_q.size() > 0 && wd_q[0].cyc <= cyc) begin
      checks++;
      failures++;
      $display("FAIL wd_missing: got no word at cyc %0d, want d=%h", cyc, wd_q[0].d);
      void'(wd_q.pop_front());
    end
  end

  task automatic check_all_zero(input string name);
    logic [127:0] v;
    v = {bus.o_en_read, bus.o_adr_out, bus.o_data, bus.o_valid, bus.o_sof, bus.o_eof,
         bus.o_extra_byte, bus.o_src, o_desc_ready};
    checks++;
    if (v != '0) begin
      failures++;
      $display("FAIL %s: got outputs %h want 0", name, v);
    end
`ifdef MEM_RD_SCHED_STATS_EN
    checks++;
    if (o_frame_cnt != '0) begin
      failures++;
      $display("FAIL %s_cnt: got %h want 0", name, o_frame_cnt);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_reset = 1'b0;
    bus.i_tx_ready = 1'b0;
    i_desc_valid = '0;
    i_desc = '0;
    for (int s = 0; s < NS; s++) pops[s] = 0;
    repeat (3) step(1'b0, 1'b0);
    check_all_zero("reset_state");

    // Directed frames: plain, region-0 wrap, back-to-back from the same source.
    push(0, 10, 13, 2);
    push(0, 1533, 1, 1);
    drain(100);
    push(2, 3071, 3071, 3);
    push(2, 4606, 3072, 0);
    drain(100);

    // Egress not ready: descriptor must wait, then pop on the first ready cycle.
    push(1, 1600, 1602, 1);
    repeat (10) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++;
    if (!popped) begin
      failures++;
      $display("FAIL tx_ready_pop: got no pop on ready cycle, want pop of src1");
    end
    drain(100);

    // All sources backlogged with one-word frames.
    for (int k = 0; k < 2; k++) begin
      push(0, 5 + k, 5 + k, k);
      push(1, 2000 + k, 2000 + k, 1 + k);
      push(2, 4000 + k, 4000 + k, 2 + k);
    end
    drain(100);

    // Random traffic with random egress backpressure.
    for (int c = 0; c < 500; c++) begin
      int s, st, len;
      if ($urandom_range(0, 3) == 0) begin
        s = $urandom_range(0, NS - 1);
        if (fifo[s].size() < 3) begin
          len = $urandom_range(1, 10);
          st = ($urandom_range(0, 1) == 1) ? $urandom_range(lo_of(s), hi_of(s))
                                           : hi_of(s) - $urandom_range(0, 5);
          push(s, st, advance(s, st, len - 1), $urandom_range(0, 3));
        end
      end
      step(1'b1, ($urandom_range(0, 9) < 7));
    end
    drain(2000);

`ifdef MEM_RD_SCHED_STATS_EN
    for (int s = 0; s < NS; s++) begin
      checks++;
      if (int'(o_frame_cnt[s*16 +: 16]) != pops[s]) begin
        failures++;
        $display("FAIL frame_cnt%0d: got %0d want %0d", s, o_frame_cnt[s*16 +: 16], pops[s]);
      end
    end
`endif

    // Reset in the third read of an 8-word frame.
    push(1, 1600, 1607, 2);
    n = 0;
    popped = 1'b0;
    while (!popped && n < 50) begin
      step(1'b1, 1'b1);
      n++;
    end
    checks++;
    if (!popped) begin
      failures++;
      $display("FAIL reset_frame_pop: got no pop, want pop of src1");
    end
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    @(posedge clk);
    #1;
    rd_q.delete();
    wd_q.delete();
    @(negedge clk);
    check_all_zero("mid_frame_reset");
    last_g = NS - 1;
    next_free = 0;
    push(2, 3100, 3101, 1);
    push(0, 700, 702, 3);
    step(1'b1, 1'b1);
    checks++;
    if (o_desc_ready !== 3'b001) begin
      failures++;
      $display("FAIL post_reset_grant: got %b want 001", o_desc_ready);
    end
    drain(100);

    checks++;
    if (rd_q.size() != 0 || wd_q.size() != 0) begin
      failures++;
      $display("FAIL final_queues: got %0d reads %0d words pending, want 0", rd_q.size(), wd_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
